// File: rtl/sr_ff_bank.sv
// Multi-channel SR/JK/D/T storage bank with one shared runtime mode.
// It also keeps sticky per-channel invalid-input flags and a saturating count of invalid cycles.
module sr_ff_bank #(
    parameter int                 WIDTH          = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE    = {WIDTH{1'b0}},
    parameter int                 INVALID_POLICY = 0,
    parameter int                 CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             err_clr,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] Qn1,
    output logic [WIDTH-1:0] err_flags,
    output logic [CNT_W-1:0] err_count,
    output logic             err_any
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] flags_q, flags_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] invalid;
    logic             any_invalid;
    logic [CNT_W-1:0] count_inc;

    always_comb begin
        q_d     = q_q;
        invalid = '0;
        if (en) begin
            case (mode)
                MODE_SR: begin
                    invalid = S & R;
                    for (int i = 0; i < WIDTH; i++) begin
                        case ({S[i], R[i]})
                            2'b01:   q_d[i] = 1'b0;
                            2'b10:   q_d[i] = 1'b1;
                            2'b11: begin
                                // S=R=1 is resolved once, at elaboration, by INVALID_POLICY.
                                case (INVALID_POLICY)
                                    1:       q_d[i] = 1'b1;
                                    2:       q_d[i] = 1'b0;
                                    3:       q_d[i] = ~q_q[i];
                                    default: q_d[i] = q_q[i];
                                endcase
                            end
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                end
                MODE_JK: q_d = (S & ~q_q) | (~R & q_q);
                MODE_D:  q_d = S;
                MODE_T:  q_d = q_q ^ S;
                default: q_d = q_q;
            endcase
        end
    end

    always_comb begin
        any_invalid = |invalid;
        count_inc   = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
        if (err_clr) begin
            // A same-cycle invalid event beats the clear: it is recorded fresh.
            flags_d = invalid;
            count_d = any_invalid ? CNT_ONE : '0;
        end else begin
            flags_d = flags_q | invalid;
            count_d = any_invalid ? count_inc : count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= RESET_VALUE;
            flags_q <= '0;
            count_q <= '0;
        end else begin
            q_q     <= q_d;
            flags_q <= flags_d;
            count_q <= count_d;
        end
    end

    assign Qn        = q_q;
    assign Qn1       = ~q_q;
    assign err_flags = flags_q;
    assign err_count = count_q;
    assign err_any   = |flags_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: four instances (one per INVALID_POLICY, WIDTH=4, CNT_W=2) share random
// and directed stimulus; a reference model queues expectations that a monitor pops and checks.
module tb_sr_ff_bank;

    localparam int          W   = 4;
    localparam int          CW  = 2;
    localparam int          NP  = 4;
    localparam logic [W-1:0] RV = 4'b0101;
    localparam int          EW  = CW + 2 * W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [W-1:0]    s_in = '0;
    logic [W-1:0]    r_in = '0;
    logic            err_clr = 1'b0;

    logic [W-1:0]    qn    [NP];
    logic [W-1:0]    qn1   [NP];
    logic [W-1:0]    flags [NP];
    logic [CW-1:0]   cnt   [NP];
    logic            any   [NP];

    // Model state per policy instance, kept as plain bits and an integer count.
    logic [W-1:0]    m_q [NP];
    logic [W-1:0]    m_f [NP];
    int              m_c [NP];

    logic [NP*EW-1:0] exp_q[$];
    event            rst_ev;
    int              n_checks = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    for (genvar p = 0; p < NP; p++) begin : g_dut
        sr_ff_bank #(
            .WIDTH(W), .RESET_VALUE(RV), .INVALID_POLICY(p), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .mode(mode), .S(s_in), .R(r_in),
            .err_clr(err_clr), .Qn(qn[p]), .Qn1(qn1[p]), .err_flags(flags[p]),
            .err_count(cnt[p]), .err_any(any[p])
        );
    end

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_q[p] = RV;
            m_f[p] = '0;
            m_c[p] = 0;
        end
    endtask

    task automatic push_expected();
        logic [NP*EW-1:0] e;
        logic [CW-1:0]    c;
        for (int p = 0; p < NP; p++) begin
            c = CW'(m_c[p]);
            e[p*EW +: EW] = {c, m_f[p], m_q[p]};
        end
        exp_q.push_back(e);
    endtask

    // One clock of behaviour for every instance, straight from the channel rules.
    task automatic model_step();
        logic [W-1:0] bad;
        logic         sb, rb, qb;
        for (int p = 0; p < NP; p++) begin
            bad = '0;
            if (en) begin
                for (int i = 0; i < W; i++) begin
                    sb = s_in[i];
                    rb = r_in[i];
                    qb = m_q[p][i];
                    if (mode == 2'd0) begin
                        if (sb && !rb) qb = 1'b1;
                        else if (!sb && rb) qb = 1'b0;
                        else if (sb && rb) begin
                            bad[i] = 1'b1;
                            if (p == 1) qb = 1'b1;
                            else if (p == 2) qb = 1'b0;
                            else if (p == 3) qb = !qb;
                        end
                    end else if (mode == 2'd1) begin
                        if (sb && rb) qb = !qb;
                        else if (sb) qb = 1'b1;
                        else if (rb) qb = 1'b0;
                    end else if (mode == 2'd2) begin
                        qb = sb;
                    end else begin
                        if (sb) qb = !qb;
                    end
                    m_q[p][i] = qb;
                end
            end
            if (err_clr) begin
                m_f[p] = bad;
                m_c[p] = (bad != 0) ? 1 : 0;
            end else begin
                m_f[p] = m_f[p] | bad;
                if (bad != 0) m_c[p] = (m_c[p] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_c[p] + 1;
            end
        end
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (!rst) model_step();
        push_expected();
    end

    task automatic check(input string name, input int p, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s policy=%0d got=%b expected=%b at %0t", name, p, got, want, $time);
        end
    endtask

    always begin
        logic [NP*EW-1:0] e;
        logic [EW-1:0]    ep;
        @(posedge clk or rst_ev);
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int p = 0; p < NP; p++) begin
                ep = e[p*EW +: EW];
                check("qn", p, qn[p], ep[W-1:0]);
                check("qn1", p, qn1[p], ~ep[W-1:0]);
                check("err_flags", p, flags[p], ep[2*W-1:W]);
                check("err_count", p, W'(cnt[p]), W'(ep[EW-1:2*W]));
                check("err_any", p, W'(any[p]), W'(|ep[2*W-1:W]));
            end
        end
    end

    task automatic drive(input logic e_i, input logic [1:0] m_i, input logic [W-1:0] s_i,
                         input logic [W-1:0] r_i, input logic c_i);
        @(negedge clk);
        en = e_i;
        mode = m_i;
        s_in = s_i;
        r_in = r_i;
        err_clr = c_i;
    endtask

    // Asynchronous pulse wholly between two rising edges; outputs are checked while it is high.
    task automatic reset_pulse();
        #1;
        rst = 1'b1;
        model_reset();
        push_expected();
        ->rst_ev;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        drive(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;

        // Reset mid-run from all-ones.
        drive(1'b1, 2'b10, 4'b1111, 4'b0000, 1'b0);
        drive(1'b1, 2'b10, 4'b1111, 4'b0000, 1'b0);
        reset_pulse();

        // SR basic from zero.
        drive(1'b1, 2'b10, 4'b0000, 4'b0000, 1'b0);
        drive(1'b1, 2'b00, 4'b0011, 4'b0000, 1'b0);
        drive(1'b1, 2'b00, 4'b0000, 4'b0001, 1'b0);
        drive(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0);

        // Invalid held 5 cycles from Qn=1000, then clear priority, then clear alone.
        drive(1'b1, 2'b10, 4'b1000, 4'b0000, 1'b0);
        repeat (5) drive(1'b1, 2'b00, 4'b1000, 4'b1000, 1'b0);
        drive(1'b1, 2'b00, 4'b1000, 4'b1000, 1'b1);
        drive(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1);
        drive(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);

        // Modes from zero.
        drive(1'b1, 2'b10, 4'b0000, 4'b0000, 1'b0);
        drive(1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0);
        drive(1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0);
        drive(1'b1, 2'b10, 4'b1010, 4'b0000, 1'b0);
        drive(1'b1, 2'b11, 4'b0110, 4'b0000, 1'b0);

        // Enable gating with S=R=1 in SR mode.
        repeat (3) drive(1'b0, 2'b00, 4'b1111, 4'b1111, 1'b0);

        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), W'($urandom),
                  W'($urandom), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 49) == 0) reset_pulse();
        end

        drive(1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #4;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d expected=0 queued entries", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised, multi-channel successor to the single-bit SR flip-flop. It holds WIDTH independent storage bits behind one clock and one asynchronous reset, each bit driven by per-channel S/R inputs. A shared runtime mode selects SR, JK, D or T behaviour, and a compile-time policy resolves the S=R=1 condition. The block also tracks invalid-input events with sticky per-channel flags and a saturating counter, and serves as the general register-bank primitive for control and status logic.

## Interface
- WIDTH, 8, number of channels (1..32)
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Qn on reset
- INVALID_POLICY, 0, SR-mode action on S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
- CNT_W, 8, width of err_count

- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- en  in  1  update enable; 0 = all channels hold
- mode  in  2  00 SR, 01 JK, 10 D (S is D, R ignored), 11 T (S is T, R ignored)
- S  in  WIDTH  per-channel set / J / D / T input
- R  in  WIDTH  per-channel reset / K input
- err_clr  in  1  synchronous clear of err_flags and err_count
- Qn  out  WIDTH  registered state
- Qn1  out  WIDTH  complement of Qn, always ~Qn
- err_flags  out  WIDTH  sticky per-channel invalid-input flags
- err_count  out  CNT_W  saturating count of cycles with at least one invalid channel
- err_any  out  1  OR-reduction of err_flags

## Operation
- Each channel is evaluated independently each rising edge when en=1. mode is sampled at that same edge and applies to all channels.
- SR mode, per channel (S,R):
  - 00 hold
  - 01 Qn=0
  - 10 Qn=1
  - 11 is invalid and resolved by INVALID_POLICY
- JK mode: 00 hold, 01 clear, 10 set, 11 toggle. Never invalid.
- D mode: Qn=S. T mode: Qn^=S. Never invalid.
- Invalid event: en=1, mode=00, S[i]&R[i]=1. Each such event sets err_flags[i].
- err_count increments by 1 on every clock where at least one channel is invalid, regardless of how many channels are invalid. It saturates at 2^CNT_W-1 and does not wrap.
- err_clr=1 clears err_flags and err_count. If an invalid event occurs in the same cycle, the event wins:
  - each offending err_flags[i] ends at 1;
  - err_count ends at 1.
- en=0: Qn holds. No invalid events are recorded, even if S&R=1. err_clr still acts.
- Qn1 and err_any are combinational from the registers; no extra latency.

## Timing
- Reset (rst=1, asynchronous, takes effect immediately without a clock edge):
  - Qn=RESET_VALUE, Qn1=~RESET_VALUE
  - err_flags=0, err_count=0, err_any=0
- Reset held: all registers stay at reset values and clock edges are ignored.
- Reset deasserted: the first edge that updates state is the first rising edge with rst=0.
- Reset asserted mid-operation overrides any in-flight update on the same edge.
- Latency: one clock from input sampling to Qn, err_flags and err_count.
- Inputs must be stable around the rising edge; there are no combinational paths from inputs to outputs.
- Simultaneous set/clear of different channels in one cycle are fully independent.

## Test plan
- Reset mid-run, WIDTH=4, RESET_VALUE=4'b0101:
  - stimulus: drive Qn to 4'b1111, then pulse rst between edges;
  - required: Qn=0101 and Qn1=1010 immediately, before the next edge, and err_count=0.
- SR basic, en=1, mode=00:
  - stimulus: S=4'b0011, R=0, then S=0, R=4'b0001, then S=R=0;
  - required: Qn goes 0011, then 0010, then holds 0010; err_any stays 0.
- Invalid policies, S=R=4'b1000 from Qn=4'b1000:
  - required: policy 0 → 1000, 1 → 1000, 2 → 0000, 3 → 0000;
  - in every policy err_flags=1000 and err_count increments by 1 per cycle held.
- Saturation and clear priority, CNT_W=2:
  - stimulus: hold an invalid input for 5 cycles;
  - required: err_count reads 1, 2, 3, 3, 3;
  - stimulus: err_clr with an invalid input in the same cycle;
  - required: err_count=1 and the flag stays set;
  - stimulus: err_clr alone;
  - required: err_count=0, err_flags=0.
- Modes, from Qn=4'b0000:
  - JK with S=R=4'b1111 → Qn=1111, then 0000 (no errors);
  - D with S=4'b1010 → 1010;
  - T with S=4'b0110 → 1100.
- Enable gating:
  - stimulus: en=0 with S=R=4'b1111 in SR mode for 3 cycles;
  - required: Qn unchanged, err_flags=0, err_count=0.
